// File: rtl/uart_denetleyici.sv
// UART control block: register file, RX pop / TX push sequencing, sticky error flags and interrupt.
// Latency: req_i seen in IDLE -> ack_o next cycle; a WDATA write into a full TX queue waits,
// and the whole request-to-ack time is bounded by TX_TIMEOUT cycles, after which the byte is dropped.
// Ports: bus (req_i/we_i/addr_i/wdata_i -> rdata_o/ack_o), baud_div_o, RX queue side
// (rx_data_i/rx_full_i/rx_empty_i -> rx_re_o/rx_stall_o), TX queue side
// (tx_full_i/tx_empty_i -> tx_data_o/tx_we_o), level interrupt irq_o.
module uart_denetleyici #(
  parameter int unsigned TX_TIMEOUT     = 1024,
  parameter logic [15:0] RESET_BAUD_DIV = 16'd867
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic [15:0] baud_div_o,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_full_i,
  input  logic        rx_empty_i,
  output logic        rx_re_o,
  output logic        rx_stall_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_we_o,
  input  logic        tx_full_i,
  input  logic        tx_empty_i,
  output logic        irq_o
);

  localparam int unsigned CNT_W = $clog2(TX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_TIMEOUT - 1);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_RDATA  = 3'd2;
  localparam logic [2:0] A_WDATA  = 3'd3;
  localparam logic [2:0] A_IRQ_EN = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP    = 2'd1,
    TX_WAIT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             tx_en;
  logic             rx_en;
  logic [15:0]      baud_div;
  logic [3:0]       irq_en;
  logic             rx_overrun;
  logic             tx_drop;
  logic             rx_underflow;
  logic             rx_full_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      rdata_q;
  logic [7:0]       tx_data_q;
  logic             pop_q;
  logic             push_q;
  logic             irq_q;

  logic [2:0]       sel;
  logic             start;
  logic             wd_write;
  logic             tx_timeout;
  logic [31:0]      rd_mux;
  logic [2:0]       sticky_set;
  logic [2:0]       sticky_clr;
  logic             unused_bits;

  assign sel      = addr_i[4:2];
  assign start    = (state == IDLE) && req_i;
  assign wd_write = we_i && (sel == A_WDATA);

  // The wait counter already includes the IDLE cycle, so this fires after TX_TIMEOUT-1 waits.
  assign tx_timeout = (state == TX_WAIT) && tx_full_i && (wait_cnt == CNT_LAST);

  assign rx_stall_o = ~rx_en | rx_full_i;
  assign baud_div_o = baud_div;
  assign tx_data_o  = tx_data_q;
  assign rdata_o    = rdata_q;
  assign irq_o      = irq_q;

  assign unused_bits = ^{addr_i[1:0], wdata_i[15:8]};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (wd_write && tx_en && tx_full_i) begin
            state_nxt = TX_WAIT;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      TX_WAIT: begin
        if (!tx_full_i || (wait_cnt == CNT_LAST)) begin
          state_nxt = RESP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Strobes are derived from RESP so they are exactly one cycle and clear on reset at once.
  always_comb begin
    ack_o   = 1'b0;
    rx_re_o = 1'b0;
    tx_we_o = 1'b0;
    if (state == RESP) begin
      ack_o   = 1'b1;
      rx_re_o = pop_q;
      tx_we_o = push_q;
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    rd_mux = 32'h0;
    case (sel)
      A_CTRL:   rd_mux = {baud_div, 14'h0, rx_en, tx_en};
      A_STATUS: rd_mux = {25'h0, rx_underflow, tx_drop, rx_overrun,
                          rx_empty_i, rx_full_i, tx_empty_i, tx_full_i};
      A_RDATA:  rd_mux = rx_empty_i ? 32'h0 : {24'h0, rx_data_i};
      A_IRQ_EN: rd_mux = {28'h0, irq_en};
      default:  rd_mux = 32'h0;
    endcase
  end

  // ---------------- TX wait counter ----------------
  // 1 on entry to TX_WAIT, +1 per waiting cycle, back to 0 whenever not waiting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (state_nxt == TX_WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // ---------------- transaction capture ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q   <= 32'h0;
      pop_q     <= 1'b0;
      push_q    <= 1'b0;
      tx_data_q <= 8'h0;
    end else begin
      if (start) begin
        rdata_q <= we_i ? 32'h0 : rd_mux;
        pop_q   <= !we_i && (sel == A_RDATA) && !rx_empty_i;
        push_q  <= wd_write && tx_en && !tx_full_i;
        if (wd_write && tx_en) begin
          tx_data_q <= wdata_i[7:0];
        end
      end else if (state == TX_WAIT) begin
        // Leaving on timeout means the queue is still full, so no push.
        push_q <= !tx_full_i;
      end
    end
  end

  // ---------------- configuration registers ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_en    <= 1'b0;
      rx_en    <= 1'b0;
      baud_div <= RESET_BAUD_DIV;
      irq_en   <= 4'h0;
    end else if (start && we_i) begin
      if (sel == A_CTRL) begin
        tx_en    <= wdata_i[0];
        rx_en    <= wdata_i[1];
        baud_div <= wdata_i[31:16];
      end
      if (sel == A_IRQ_EN) begin
        irq_en <= wdata_i[3:0];
      end
    end
  end

  // ---------------- sticky flags ----------------
  // Bit order {rx_underflow, tx_drop, rx_overrun} matches STATUS[6:4]; a set beats a same-cycle clear.
  assign sticky_set = {start && !we_i && (sel == A_RDATA) && rx_empty_i,
                       tx_timeout,
                       rx_full_i && !rx_full_q && rx_en};
  assign sticky_clr = (start && we_i && (sel == A_STATUS)) ? wdata_i[6:4] : 3'b000;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_full_q    <= 1'b0;
      rx_overrun   <= 1'b0;
      tx_drop      <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      rx_full_q    <= rx_full_i;
      rx_overrun   <= (rx_overrun   & ~sticky_clr[0]) | sticky_set[0];
      tx_drop      <= (tx_drop      & ~sticky_clr[1]) | sticky_set[1];
      rx_underflow <= (rx_underflow & ~sticky_clr[2]) | sticky_set[2];
    end
  end

  // ---------------- interrupt ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(irq_en & {tx_empty_i, tx_drop, rx_overrun, ~rx_empty_i});
    end
  end

endmodule

// File: tb/tb_uart_denetleyici.sv
// Bench for uart_denetleyici: transaction-level register model plus per-cycle output compare.
module tb_uart_denetleyici;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [4:0]  addr_i = 5'h0;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic [15:0] baud_div_o;
  logic [7:0]  rx_data_i = 8'h0;
  logic        rx_full_i = 1'b0;
  logic        rx_empty_i = 1'b1;
  logic        rx_re_o;
  logic        rx_stall_o;
  logic [7:0]  tx_data_o;
  logic        tx_we_o;
  logic        tx_full_i = 1'b0;
  logic        tx_empty_i = 1'b1;
  logic        irq_o;

  uart_denetleyici #(.TX_TIMEOUT(TO), .RESET_BAUD_DIV(16'd867)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o), .baud_div_o(baud_div_o),
    .rx_data_i(rx_data_i), .rx_full_i(rx_full_i), .rx_empty_i(rx_empty_i),
    .rx_re_o(rx_re_o), .rx_stall_o(rx_stall_o), .tx_data_o(tx_data_o),
    .tx_we_o(tx_we_o), .tx_full_i(tx_full_i), .tx_empty_i(tx_empty_i), .irq_o(irq_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;

  // Register model (written only by the compare process).
  logic [15:0] m_baud = 16'd867;
  logic        m_tx_en = 1'b0, m_rx_en = 1'b0;
  logic [3:0]  m_irq_en = 4'h0;
  logic        m_ovr = 1'b0, m_drop = 1'b0, m_unf = 1'b0;
  logic        irq_exp = 1'b0, full_last = 1'b0;

  // Current transaction (written only by the driver).
  logic        txn_active = 1'b0;
  logic        cur_we = 1'b0;
  logic [2:0]  cur_addr = 3'd0;
  logic [31:0] cur_wdata = 32'h0;
  logic        cur_pop = 1'b0, cur_push = 1'b0, cur_drop = 1'b0, cur_unf = 1'b0;
  int          cur_lat = 1, cur_k = 0;
  logic [31:0] exp_rdata = 32'h0;

  // Hand-computed literal expectations.
  logic        lit_rd_en = 1'b0, lit_lat_en = 1'b0, lit_baud_en = 1'b0, lit_irq_en = 1'b0;
  logic [31:0] lit_rd = 32'h0;
  int          lit_lat = 0;
  logic [15:0] lit_baud = 16'h0;
  logic        lit_irq = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {m_baud, 14'h0, m_rx_en, m_tx_en};
      3'd1:    return {25'h0, m_unf, m_drop, m_ovr, rx_empty_i, rx_full_i, tx_empty_i, tx_full_i};
      3'd2:    return rx_empty_i ? 32'h0 : {24'h0, rx_data_i};
      3'd4:    return {28'h0, m_irq_en};
      default: return 32'h0;
    endcase
  endfunction

  // Per-cycle compare, sampled on the falling edge.
  initial begin
    bit ack_now;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_rx_re", 32'(rx_re_o), 32'h0);
        chk("rst_tx_we", 32'(tx_we_o), 32'h0);
        chk("rst_tx_data", 32'(tx_data_o), 32'h0);
        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("rst_baud", 32'(baud_div_o), 32'd867);
        chk("rst_rx_stall", 32'(rx_stall_o), 32'h1);
        m_baud = 16'd867; m_tx_en = 0; m_rx_en = 0; m_irq_en = 0;
        m_ovr = 0; m_drop = 0; m_unf = 0; irq_exp = 0; full_last = 0;
      end else begin
        ack_now = txn_active && (cur_k == cur_lat);
        if (ack_now) begin
          if (cur_we) begin
            case (cur_addr)
              3'd0: begin m_tx_en = cur_wdata[0]; m_rx_en = cur_wdata[1]; m_baud = cur_wdata[31:16]; end
              3'd1: begin
                if (cur_wdata[4]) m_ovr = 0;
                if (cur_wdata[5]) m_drop = 0;
                if (cur_wdata[6]) m_unf = 0;
              end
              3'd4: m_irq_en = cur_wdata[3:0];
              default: ;
            endcase
          end
          if (cur_unf) m_unf = 1;
          if (cur_drop) m_drop = 1;
        end
        chk("ack", 32'(ack_o), 32'(ack_now));
        chk("rx_re", 32'(rx_re_o), 32'(ack_now && cur_pop));
        chk("tx_we", 32'(tx_we_o), 32'(ack_now && cur_push));
        if (ack_now && cur_push) chk("tx_data", 32'(tx_data_o), 32'(cur_wdata[7:0]));
        if (ack_now && !cur_we) begin
          chk("rdata", rdata_o, exp_rdata);
          if (lit_rd_en) chk("rdata_lit", rdata_o, lit_rd);
        end
        if (ack_o && lit_lat_en) chk("ack_latency_lit", 32'(cur_k), 32'(lit_lat));
        chk("baud", 32'(baud_div_o), 32'(m_baud));
        if (lit_baud_en) chk("baud_lit", 32'(baud_div_o), 32'(lit_baud));
        chk("rx_stall", 32'(rx_stall_o), 32'(!m_rx_en || rx_full_i));
        chk("irq", 32'(irq_o), 32'(irq_exp));
        if (lit_irq_en) chk("irq_lit", 32'(irq_o), 32'(lit_irq));
        // Interrupt is registered: next cycle reflects this cycle's flags and inputs.
        irq_exp = |(m_irq_en & {tx_empty_i, m_drop, m_ovr, !rx_empty_i});
        if (rx_full_i && !full_last && m_rx_en) m_ovr = 1;
        full_last = rx_full_i;
      end
    end
  end

  // One bus transaction. f = number of cycles tx_full_i stays high from the request cycle on.
  task automatic txn(input logic we, input logic [2:0] a, input logic [31:0] wd, input int f,
                     input logic lr_en, input logic [31:0] lr, input int ll);
    @(posedge clk_i); #1;
    cur_we = we; cur_addr = a; cur_wdata = wd;
    cur_pop = !we && (a == 3'd2) && !rx_empty_i;
    cur_unf = !we && (a == 3'd2) && rx_empty_i;
    cur_push = 0; cur_drop = 0; cur_lat = 1;
    if (we && (a == 3'd3) && m_tx_en) begin
      // Request-to-ack time is bounded by TO; the byte goes out only if space appears in time.
      if (f < TO) begin cur_lat = f + 1; cur_push = 1; end
      else begin cur_lat = TO; cur_drop = 1; end
    end
    tx_full_i = (f > 0);
    exp_rdata = model_read(a);
    lit_rd_en = lr_en; lit_rd = lr; lit_lat_en = (ll > 0); lit_lat = ll;
    req_i = 1; we_i = we; addr_i = {a, 2'b00}; wdata_i = wd;
    cur_k = 0; txn_active = 1;
    for (int k = 1; k <= cur_lat; k++) begin
      @(posedge clk_i); #1;
      cur_k = k;
      tx_full_i = (k < f);
    end
    @(negedge clk_i); #1;
    req_i = 0;
    @(posedge clk_i); #1;
    txn_active = 0; tx_full_i = 0; lit_rd_en = 0; lit_lat_en = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  initial begin
    idle(3);
    rst_i = 0;
    idle(2);
    // Reset values
    txn(0, 3'd0, 32'h0, 0, 1, 32'h0363_0000, 1);
    txn(0, 3'd1, 32'h0, 0, 1, 32'h0000_000A, 1);
    // CTRL write
    txn(1, 3'd0, 32'h0010_0003, 0, 0, 32'h0, 1);
    lit_baud_en = 1; lit_baud = 16'd16;
    idle(1);
    lit_baud_en = 0;
    txn(0, 3'd0, 32'h0, 0, 1, 32'h0010_0003, 1);
    // RX pop and underflow
    rx_data_i = 8'hA5; rx_empty_i = 0;
    txn(0, 3'd2, 32'h0, 0, 1, 32'h0000_00A5, 1);
    rx_empty_i = 1;
    txn(0, 3'd2, 32'h0, 0, 1, 32'h0, 1);
    txn(0, 3'd1, 32'h0, 0, 1, 32'h0000_004A, 0);
    txn(1, 3'd1, 32'h0000_0040, 0, 0, 32'h0, 0);
    txn(0, 3'd1, 32'h0, 0, 1, 32'h0000_000A, 0);
    // TX back-pressure: full for 5 cycles, then push
    txn(1, 3'd3, 32'h0000_003C, 5, 0, 32'h0, 6);
    // TX timeout: full throughout, byte dropped
    txn(1, 3'd3, 32'h0000_0077, 20, 0, 32'h0, 8);
    txn(0, 3'd1, 32'h0, 0, 1, 32'h0000_002A, 0);
    txn(1, 3'd4, 32'h0000_0004, 0, 0, 32'h0, 0);
    lit_irq_en = 1; lit_irq = 1;
    idle(1);
    lit_irq_en = 0;
    txn(1, 3'd1, 32'h0000_0020, 0, 0, 32'h0, 0);
    idle(2);
    // Overrun on rising edge of rx_full_i
    rx_full_i = 1;
    idle(2);
    txn(0, 3'd1, 32'h0, 0, 1, 32'h0000_001E, 0);
    txn(1, 3'd4, 32'h0000_0002, 0, 0, 32'h0, 0);
    lit_irq_en = 1; lit_irq = 1;
    idle(1);
    lit_irq_en = 0;
    txn(1, 3'd1, 32'h0000_0010, 0, 0, 32'h0, 0);
    rx_full_i = 0;
    txn(0, 3'd1, 32'h0, 0, 1, 32'h0000_000A, 0);
    // Unmapped and write-only addresses
    txn(0, 3'd5, 32'h0, 0, 1, 32'h0, 1);
    txn(1, 3'd7, 32'hFFFF_FFFF, 0, 0, 32'h0, 1);
    txn(0, 3'd0, 32'h0, 0, 1, 32'h0010_0003, 0);
    txn(0, 3'd3, 32'h0, 0, 1, 32'h0, 0);
    // tx_en=0: WDATA acked without push; tx_empty interrupt source
    txn(1, 3'd0, 32'h0010_0002, 0, 0, 32'h0, 0);
    txn(1, 3'd3, 32'h0000_0099, 0, 0, 32'h0, 1);
    txn(1, 3'd4, 32'h0000_0008, 0, 0, 32'h0, 0);
    lit_irq_en = 1; lit_irq = 1;
    idle(1);
    lit_irq_en = 0;
    // rx_not_empty interrupt source
    txn(1, 3'd4, 32'h0000_0001, 0, 0, 32'h0, 0);
    rx_empty_i = 0; rx_data_i = 8'h11;
    idle(1);
    lit_irq_en = 1; lit_irq = 1;
    idle(1);
    lit_irq_en = 0;
    txn(0, 3'd2, 32'h0, 0, 1, 32'h0000_0011, 0);
    rx_empty_i = 1;
    idle(2);
    // Asynchronous reset in the middle of TX_WAIT
    txn(1, 3'd0, 32'h0020_0003, 0, 0, 32'h0, 0);
    @(posedge clk_i); #1;
    cur_we = 1; cur_addr = 3'd3; cur_wdata = 32'h0000_005A;
    cur_pop = 0; cur_unf = 0; cur_push = 0; cur_drop = 0; cur_lat = TO; cur_k = 0;
    tx_full_i = 1; req_i = 1; we_i = 1; addr_i = 5'h0C; wdata_i = 32'h0000_005A;
    txn_active = 1;
    repeat (3) begin @(posedge clk_i); #1; cur_k++; end
    rst_i = 1; req_i = 0; tx_full_i = 0; txn_active = 0;
    idle(2);
    rst_i = 0;
    idle(2);
    txn(0, 3'd0, 32'h0, 0, 1, 32'h0363_0000, 1);
    txn(0, 3'd1, 32'h0, 0, 1, 32'h0000_000A, 1);
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_denetleyici.md
Name: uart_denetleyici

Overview:
Memory-mapped control and sequencing block for the UART peripheral. It sits between the core's peripheral bus and the UART receive/transmit queues. It holds the baud divisor and enable bits, and turns bus reads/writes into single-cycle pop/push strobes for the queues. It also stalls the bus on TX back-pressure (bounded by a timeout) and tracks sticky error flags, which drive an interrupt.

Parameters:
TX_TIMEOUT, 1024, max cycles a WDATA write waits on a full TX queue before the byte is dropped
RESET_BAUD_DIV, 16'd867, baud divisor value after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
req_i  in  1  bus request, held high until ack_o
we_i  in  1  1 = write, 0 = read; valid with req_i
addr_i  in  5  byte address; [4:2] selects register
wdata_i  in  32  write data
rdata_o  out  32  read data, valid when ack_o=1
ack_o  out  1  one-cycle transaction-complete pulse
baud_div_o  out  16  divisor to RX and TX
rx_data_i  in  8  head of RX queue
rx_full_i  in  1  RX queue full
rx_empty_i  in  1  RX queue empty
rx_re_o  out  1  RX pop strobe
rx_stall_o  out  1  inhibit new RX frame start
tx_data_o  out  8  byte to TX queue
tx_we_o  out  1  TX push strobe
tx_full_i  in  1  TX queue full
tx_empty_i  in  1  TX queue empty
irq_o  out  1  level interrupt

Behaviour:
- Reset (async, any state) values:
  - ack_o=0, rdata_o=0, rx_re_o=0, tx_we_o=0, tx_data_o=0, irq_o=0.
  - baud_div_o=RESET_BAUD_DIV; CTRL enables=0; IRQ_EN=0; sticky flags=0; FSM=IDLE; timeout counter=0.
- Register map (addr_i[4:2]):
  - 0 CTRL RW: [0] tx_en, [1] rx_en, [31:16] baud_div.
  - 1 STATUS: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] rx_overrun, [5] tx_drop, [6] rx_underflow.
    - [6:4] are sticky and write-1-to-clear; others read-only.
  - 2 RDATA RO: read pops one byte.
  - 3 WDATA WO: [7:0] pushes one byte.
  - 4 IRQ_EN RW: bit i enables irq from rx_not_empty(0), overrun(1), tx_drop(2), tx_empty(3).
  - 5–7: read 0, writes ignored, ack normal.
  - Unused read bits are 0.
- rx_stall_o = ~rx_en | rx_full_i (combinational).
- FSM states: IDLE, RESP, TX_WAIT.
  - IDLE & req_i → RESP, except a WDATA write with tx_en=1 and tx_full_i=1 → TX_WAIT.
  - RESP: ack_o=1 for exactly one cycle; rdata_o registered; → IDLE.
    - Requester must drop req_i in the ack cycle; req_i seen in IDLE the next cycle starts a new transaction.
  - Latency: req_i at cycle n → ack_o at n+1 (no stall).
- RDATA read:
  - rx_empty_i=0: rdata_o={24'b0,rx_data_i} sampled in IDLE; rx_re_o pulses one cycle, coincident with ack_o.
  - rx_empty_i=1: rdata_o=0, no pop, rx_underflow set.
- WDATA write:
  - tx_en=0: ack with no push.
  - tx_full_i=0: tx_data_o=wdata_i[7:0] and tx_we_o=1 for one cycle, coincident with ack_o.
  - TX_WAIT: counter increments each cycle.
    - tx_full_i=0 → push and ack next cycle.
    - Counter reaches TX_TIMEOUT-1 while still full → no push, tx_drop set, ack; counter cleared on exit.
- rx_overrun set any cycle rx_full_i=1 & rx_en=1 & rx_empty_i=0 persists while no pop issued.
  - Simplified rule: set on rising edge of rx_full_i while rx_en.
- Simultaneous set and W1C of the same sticky bit: set wins.
- CTRL write: baud_div_o and enables update on the ack cycle. Changing baud_div mid-frame is software's responsibility.
- irq_o registered: OR over (IRQ_EN[i] & source[i]); sources = ~rx_empty_i, rx_overrun, tx_drop, tx_empty_i.

Test Plan:
- Reset → read CTRL returns 0x0363_0000, STATUS returns 0x0000_000A (tx_empty, rx_empty), irq_o=0.
- Write CTRL=0x0010_0003 → baud_div_o=16 and rx_stall_o=0 (with rx_full_i=0); ack one cycle after req.
- rx_data_i=0xA5, rx_empty_i=0, read RDATA → rdata_o=0x000000A5; one rx_re_o pulse aligned with ack. Read with rx_empty_i=1 → 0, no pulse, STATUS[6]=1; write STATUS 0x40 → bit clears.
- tx_en=1, tx_full_i=1 for 5 cycles then 0, write WDATA 0x3C → tx_we_o one pulse with tx_data_o=0x3C, ack 6 cycles after req.
- TX_TIMEOUT=8, tx_full_i held 1, write WDATA → ack at cycle 8, no tx_we_o, STATUS[5]=1; IRQ_EN=0x4 → irq_o=1.
- Assert rst_i asynchronously during TX_WAIT → all outputs return to reset values immediately, no ack, FSM IDLE.
